// File: rtl/fifo_4w2r_ctrl_pkg.sv
// fifo_4w2r_ctrl_pkg: shared FSM states and thermometer helper for the 4-write/2-read FIFO controller
package fifo_4w2r_ctrl_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  function automatic logic [2:0] therm_cnt(input logic [3:0] v);
    return v[0] ? (v[1] ? (v[2] ? (v[3] ? 3'd4 : 3'd3) : 3'd2) : 3'd1) : 3'd0;
  endfunction
endpackage

// File: rtl/fifo_flopped_4w2r.sv
// fifo_flopped_4w2r: flopped FIFO ordering state, advancing write/read pointers by the push/pop strobes
module fifo_flopped_4w2r
  import fifo_4w2r_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  input logic [3:0] push,
  input logic [1:0] pop
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [2:0] n);
    int s;
    s = int'(p) + int'(n);
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= adv(wr_ptr, therm_cnt(push));
      rd_ptr <= adv(rd_ptr, therm_cnt({2'b00, pop}));
    end
  end
endmodule

// File: rtl/fifo_4w2r_ctrl.sv
// fifo_4w2r_ctrl: occupancy/flush controller for a 4-write/2-read FIFO; FIFO_4W2R_CTRL_PERF_EN adds stall counters
module fifo_4w2r_ctrl
  import fifo_4w2r_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [3:0]       push,
  output logic [1:0]       out_valid,
  input  logic [1:0]       out_ready,
  output logic [1:0]       pop,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [CNT_W-1:0] occupancy,
  output logic             err_proto
`ifdef FIFO_4W2R_CTRL_PERF_EN
  ,
  output logic [15:0]      stall_in_cnt,
  output logic [15:0]      stall_out_cnt
`endif
);
  state_t state, state_nxt;
  logic [2:0] n_in, n_or;
  logic [CNT_W-1:0] occ_nxt;
  logic bad;
  int free;
  always_comb begin
    n_in = therm_cnt(in_valid);
    n_or = therm_cnt({2'b00, out_ready});
    free = DEPTH - int'(occupancy);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = rst || (state == RUN && i < free);
      push[i] = !rst && in_ready[i] && i < int'(n_in);
      bad = bad | (in_valid[i] != (i < int'(n_in)));
    end
    for (int j = 0; j < 2; j++) begin
      out_valid[j] = !rst && state == RUN && j < int'(occupancy);
      pop[j] = !rst && (state == FLUSH ? j < int'(occupancy) : out_valid[j] && j < int'(n_or));
      bad = bad | (out_ready[j] != (j < int'(n_or)));
    end
    occ_nxt = occupancy + CNT_W'(therm_cnt(push)) - CNT_W'(therm_cnt({2'b00, pop}));
    flush_done = !rst && state == DONE;
    state_nxt = state == RUN ? (flush_req ? FLUSH : RUN) :
                state == FLUSH ? (occ_nxt == '0 ? DONE : FLUSH) : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      occupancy <= '0;
      err_proto <= 1'b0;
    end else begin
      state <= state_nxt;
      occupancy <= occ_nxt;
      err_proto <= err_proto | bad;
    end
  end
`ifdef FIFO_4W2R_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_in_cnt <= '0;
      stall_out_cnt <= '0;
    end else begin
      if (in_valid[0] && !in_ready[0] && stall_in_cnt != '1) stall_in_cnt <= stall_in_cnt + 16'd1;
      if (out_ready[0] && !out_valid[0] && stall_out_cnt != '1) stall_out_cnt <= stall_out_cnt + 16'd1;
    end
  end
`endif
  fifo_flopped_4w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk (clk),
    .rst (rst),
    .push(push),
    .pop (pop)
  );
endmodule

// File: doc/fifo_4w2r_ctrl.md
FIFO_4W2R_CTRL -- requirements
Module: fifo_4w2r_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning total entries of the controlled 4-write/2-read FIFO; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have parameter CNT_W, default 4, meaning occupancy counter width; the minimum width that holds DEPTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port in_valid  input  4  producer lane valids, thermometer from lane 0.
REQ-006 SHALL have port in_ready  output  4  per-lane accept, thermometer from lane 0.
REQ-007 SHALL have port push  output  4  FIFO push0..push3 strobes, equal to in_valid AND in_ready.
REQ-008 SHALL have port out_valid  output  2  consumer lane valids, thermometer from lane 0.
REQ-009 SHALL have port out_ready  input  2  consumer lane takes, thermometer from lane 0.
REQ-010 SHALL have port pop  output  2  FIFO pop0/pop1 strobes.
REQ-011 SHALL have port flush_req  input  1  request to discard all stored entries.
REQ-012 SHALL have port flush_done  output  1  one-cycle pulse when a flush completes.
REQ-013 SHALL have port occupancy  output  CNT_W  registered entry count.
REQ-014 SHALL have port err_proto  output  1  sticky flag for a non-thermometer in_valid or out_ready.

Function
REQ-015 SHALL keep a registered occupancy count, updated every cycle to occupancy plus the number of push bits minus the number of pop bits.
REQ-016 In state RUN, SHALL set in_ready lane i when i is less than DEPTH minus occupancy; the decision uses only registered occupancy, with no same-cycle pop credit.
REQ-017 In state RUN, SHALL set out_valid lane j when j is less than occupancy; entries pushed this cycle become poppable next cycle.
REQ-018 In state RUN, SHALL set pop equal to out_valid AND out_ready.
REQ-019 For a non-thermometer in_valid or out_ready, SHALL use only the contiguous ones counted from lane 0, and SHALL set err_proto.
REQ-020 SHALL implement the FSM with states RUN, FLUSH and DONE.
REQ-021 On flush_req in RUN, SHALL move to FLUSH; pushes and pops already granted in that same cycle complete.
REQ-022 In FLUSH, SHALL hold in_ready and out_valid at zero, and SHALL drive pop lane j whenever j is less than occupancy, ignoring out_ready.
REQ-023 SHALL move from FLUSH to DONE in the cycle occupancy reaches 0; a flush entered with occupancy 0 reaches DONE after exactly one FLUSH cycle.
REQ-024 In DONE, SHALL assert flush_done for one cycle, then return to RUN; flush_req held high during DONE is ignored.
REQ-025 Occupancy SHALL never exceed DEPTH or go below 0 under legal stimulus.

Reset
REQ-026 On rst high at a clock edge, SHALL set state to RUN and occupancy to 0, and clear err_proto.
REQ-027 During and immediately after reset, SHALL drive in_ready=1111, push=0, out_valid=00, pop=00 and flush_done=0.
REQ-028 Reset asserted during FLUSH SHALL abort the flush with no flush_done pulse.
REQ-029 The controlled FIFO SHALL be reset in the same cycle by the same reset.

Configuration
REQ-030 With FIFO_4W2R_CTRL_PERF_EN defined, SHALL add outputs stall_in_cnt and stall_out_cnt, each 16 bits.
REQ-031 With the macro defined, stall_in_cnt SHALL count cycles where in_valid lane 0 is high and in_ready lane 0 is low, and stall_out_cnt SHALL count cycles where out_ready lane 0 is high and out_valid lane 0 is low.
REQ-032 With the macro defined, both counters SHALL saturate at the all-ones value and reset to 0.
REQ-033 Without the macro, the stall counters and their ports SHALL be absent, with no other change in behaviour.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration (RUN, FLUSH, DONE) and the thermometer-to-count helper function.
REQ-035 SHALL instantiate one sub-module, fifo_flopped_4w2r, driven by push and pop, so that data-side ordering lives entirely in that FIFO.

Verification
REQ-036 Reset, then in_valid=1111 for 2 cycles with out_ready=00 -> 8 pushes accepted, occupancy=8, and in_ready=0000 in the third cycle.
REQ-037 With occupancy=6 and in_valid=1111 -> in_ready=0011, push=0011, and occupancy=8 next cycle.
REQ-038 With occupancy=1 and out_ready=11 -> out_valid=01, pop=01, and occupancy=0 next cycle.
REQ-039 With occupancy=7 and flush_req pulsed -> 4 FLUSH cycles popping 11, 11, 11, 01, then flush_done for 1 cycle, then RUN with occupancy=0.
REQ-040 in_valid=0101 -> treated as 0001, one push, and err_proto=1 until the next rst.
REQ-041 With occupancy=8 and in_valid=1111, out_ready=11 in the same cycle -> push=0000, pop=11, occupancy=6, and in_ready=0011 next cycle.
